// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for the MEM stage: word-wide memory accesses, sub-word
// extract/extend, read-modify-write sub-word stores. Optional LSU_ACCESS_CNT_EN adds access counters.
module lsu_mem_master #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_range_err
`ifdef LSU_ACCESS_CNT_EN
  ,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt,
  output logic [31:0] fault_cnt
`endif
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LD_ISSUE   = 3'd1;
  localparam logic [2:0] S_LD_CAPTURE = 3'd2;
  localparam logic [2:0] S_RMW_ISSUE  = 3'd3;
  localparam logic [2:0] S_RMW_MERGE  = 3'd4;
  localparam logic [2:0] S_ST_WRITE   = 3'd5;
  localparam logic [2:0] S_RESP       = 3'd6;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Reserved funct3 encodings behave as full-word accesses.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  logic [2:0]  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  assign req_ready = (state == S_IDLE);

  // Request checks, evaluated on the raw request in IDLE.
  logic [1:0]  req_size;
  logic [32:0] end_addr;
  logic        mis_chk;
  logic        rng_chk;

  assign req_size = size_of(req_funct3);
  assign end_addr = {1'b0, req_addr} + 33'd3;
  assign mis_chk  = ((req_size == SZ_H) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign rng_chk  = (end_addr >= 33'(MEM_BYTES));

  // Load lane extraction and extension.
  logic [1:0]  q_size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        ld_signed;
  logic [31:0] ld_result;

  assign q_size    = size_of(f3_q);
  assign byte_sel  = mem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel  = mem_rdata[{off_q[1], 4'b0000} +: 16];
  assign ld_signed = ~f3_q[2];

  always_comb begin
    ld_result = mem_rdata;
    case (q_size)
      SZ_B:    ld_result = {{24{ld_signed & byte_sel[7]}}, byte_sel};
      SZ_H:    ld_result = {{16{ld_signed & half_sel[15]}}, half_sel};
      default: ld_result = mem_rdata;
    endcase
  end

  // Store lane merge: replicate the store data across the word, then mask in one lane.
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  always_comb begin
    if (q_size == SZ_B) begin
      lane_mask = 32'h0000_00FF << {off_q, 3'b000};
      lane_data = {4{wdata_q[7:0]}};
    end else begin
      lane_mask = 32'h0000_FFFF << {off_q[1], 4'b0000};
      lane_data = {2{wdata_q}};
    end
    merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      f3_q            <= 3'd0;
      off_q           <= 2'd0;
      wdata_q         <= 16'd0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= 32'd0;
      mem_wdata       <= 32'd0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'd0;
      resp_misaligned <= 1'b0;
      resp_range_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            f3_q     <= req_funct3;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            mem_addr <= {req_addr[31:2], 2'b00};
            if (mis_chk) begin
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
              resp_rdata      <= 32'd0;
              state           <= S_RESP;
            end else if (rng_chk) begin
              resp_valid     <= 1'b1;
              resp_range_err <= 1'b1;
              resp_rdata     <= 32'd0;
              state          <= S_RESP;
            end else if (!req_we) begin
              mem_read <= 1'b1;
              state    <= S_LD_ISSUE;
            end else if (req_size == SZ_W) begin
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= S_ST_WRITE;
            end else begin
              mem_read <= 1'b1;
              state    <= S_RMW_ISSUE;
            end
          end
        end
        S_LD_ISSUE: begin
          mem_read <= 1'b0;
          state    <= S_LD_CAPTURE;
        end
        S_LD_CAPTURE: begin
          resp_rdata <= ld_result;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RMW_ISSUE: begin
          mem_read <= 1'b0;
          state    <= S_RMW_MERGE;
        end
        S_RMW_MERGE: begin
          mem_wdata <= merged;
          mem_write <= 1'b1;
          state     <= S_ST_WRITE;
        end
        S_ST_WRITE: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= 32'd0;
          state      <= S_RESP;
        end
        S_RESP: begin
          resp_valid      <= 1'b0;
          resp_misaligned <= 1'b0;
          resp_range_err  <= 1'b0;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_ACCESS_CNT_EN
  // Counters step on the same edge that raises resp_valid for the matching request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_cnt  <= 32'd0;
      store_cnt <= 32'd0;
      fault_cnt <= 32'd0;
    end else begin
      if ((state == S_IDLE) && req_valid && (mis_chk || rng_chk))
        fault_cnt <= fault_cnt + 32'd1;
      if (state == S_LD_CAPTURE)
        load_cnt <= load_cnt + 32'd1;
      if (state == S_ST_WRITE)
        store_cnt <= store_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed vector table, back-pressure and mid-RMW reset
// sequences, then random requests checked against a byte-level memory model.
module tb_lsu_mem_master;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, resp_misaligned, resp_range_err;
  logic [31:0] resp_rdata;
`ifdef LSU_ACCESS_CNT_EN
  logic [31:0] load_cnt, store_cnt, fault_cnt;
`endif

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_range_err(resp_range_err)
`ifdef LSU_ACCESS_CNT_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt), .fault_cnt(fault_cnt)
`endif
  );

  // Word-organised synchronous data memory; read wins over write.
  logic [31:0] mem [0:MEM_BYTES/4-1];
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_addr[9:2]];
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Reference: flat byte array, updated by request semantics.
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  int n_tests = 0, n_fail = 0;
  int ecl = 0, ecs = 0, ecf = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rdata,
                                output bit mis, output bit rng, output int lat,
                                output logic [31:0] wword);
    int nb;
    logic [31:0] base;
    nb = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    mis = (addr % nb) != 0;
    rng = !mis && ((longint'(addr) + 3) >= MEM_BYTES);
    rdata = 32'd0; wword = 32'd0;
    if (mis || rng) begin lat = 1; return; end
    if (!we) begin
      lat = 3;
      for (int i = 0; i < nb; i++) rdata = rdata | (32'(ref_mem[addr + i]) << (8 * i));
      if (nb < 4 && (f3 == 3'd0 || f3 == 3'd1) && rdata[8*nb-1])
        rdata = rdata | ~((32'd1 << (8 * nb)) - 32'd1);
    end else begin
      lat = (nb == 4) ? 2 : 4;
      for (int i = 0; i < nb; i++) ref_mem[addr + i] = wd[8*i +: 8];
      base = addr & ~32'd3;
      for (int i = 0; i < 4; i++) wword[8*i +: 8] = ref_mem[base + i];
    end
  endfunction

  task automatic run_req(input string name, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rdata, input bit e_mis, input bit e_rng,
                         input int e_lat, input logic [31:0] e_wword);
    int lat, nrd, nwr, guard, e_nrd, e_nwr;
    logic [31:0] got_w;
    bit bad_addr, both, done;
    e_nrd = (e_lat == 3 || e_lat == 4) ? 1 : 0;
    e_nwr = (e_lat == 2 || e_lat == 4) ? 1 : 0;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    chk({name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; got_w = 32'd0; bad_addr = 0; both = 0; done = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; got_w = mem_wdata; end
      if ((mem_read || mem_write) && mem_addr !== {addr[31:2], 2'b00}) bad_addr = 1;
      if (mem_read && mem_write) both = 1;
      if (resp_valid) done = 1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: no resp_valid within 12 cycles", name);
      return;
    end
    if (e_mis || e_rng) ecf++; else if (we) ecs++; else ecl++;
    chk({name, " latency"}, 32'(lat), 32'(e_lat));
    chk({name, " rdata"}, resp_rdata, e_rdata);
    chk({name, " misaligned"}, 32'(resp_misaligned), 32'(e_mis));
    chk({name, " range_err"}, 32'(resp_range_err), 32'(e_rng));
    chk({name, " reads"}, 32'(nrd), 32'(e_nrd));
    chk({name, " writes"}, 32'(nwr), 32'(e_nwr));
    if (e_nwr != 0) chk({name, " wword"}, got_w, e_wword);
    chk({name, " mem_addr"}, 32'(bad_addr), 32'd0);
    chk({name, " rd_wr_overlap"}, 32'(both), 32'd0);
`ifdef LSU_ACCESS_CNT_EN
    chk({name, " load_cnt"}, load_cnt, 32'(ecl));
    chk({name, " store_cnt"}, store_cnt, 32'(ecs));
    chk({name, " fault_cnt"}, fault_cnt, 32'(ecf));
`endif
    @(negedge clk);
    chk({name, " resp_cleared"}, {29'd0, resp_valid, resp_misaligned, resp_range_err}, 32'd0);
    chk({name, " ready_after"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    string       name;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, exp_rdata;
    bit          exp_mis, exp_rng;
    int          exp_lat;
    logic [31:0] exp_wword;
  } vec_t;

  function automatic vec_t mk(string n, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, bit mis, bit rng, int lat, logic [31:0] ww);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = rd;
    v.exp_mis = mis; v.exp_rng = rng; v.exp_lat = lat; v.exp_wword = ww;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [31:0] m_rd, m_ww, wd, addr;
    bit m_mis, m_rng, we;
    int m_lat, nwr, r;
    logic [2:0] f3;

    for (int i = 0; i < MEM_BYTES / 4; i++) mem[i] = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset resp", {29'd0, resp_valid, resp_misaligned, resp_range_err}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;

    tbl.push_back(mk("SW_10",    1, 3'd2, 32'h10, 32'h8000FF7F, 0, 0, 0, 2, 32'h8000FF7F));
    tbl.push_back(mk("LW_10",    0, 3'd2, 32'h10, 0, 32'h8000FF7F, 0, 0, 3, 0));
    tbl.push_back(mk("LB_10",    0, 3'd0, 32'h10, 0, 32'h0000007F, 0, 0, 3, 0));
    tbl.push_back(mk("LB_11",    0, 3'd0, 32'h11, 0, 32'hFFFFFFFF, 0, 0, 3, 0));
    tbl.push_back(mk("LBU_11",   0, 3'd4, 32'h11, 0, 32'h000000FF, 0, 0, 3, 0));
    tbl.push_back(mk("LH_12",    0, 3'd1, 32'h12, 0, 32'hFFFF8000, 0, 0, 3, 0));
    tbl.push_back(mk("LHU_12",   0, 3'd5, 32'h12, 0, 32'h00008000, 0, 0, 3, 0));
    tbl.push_back(mk("L011_10",  0, 3'd3, 32'h10, 0, 32'h8000FF7F, 0, 0, 3, 0));
    tbl.push_back(mk("SB_13",    1, 3'd0, 32'h13, 32'h123456AA, 0, 0, 0, 4, 32'hAA00FF7F));
    tbl.push_back(mk("LW_10b",   0, 3'd2, 32'h10, 0, 32'hAA00FF7F, 0, 0, 3, 0));
    tbl.push_back(mk("SH_10",    1, 3'd1, 32'h10, 32'hCAFE1234, 0, 0, 0, 4, 32'hAA001234));
    tbl.push_back(mk("LW_10c",   0, 3'd2, 32'h10, 0, 32'hAA001234, 0, 0, 3, 0));
    tbl.push_back(mk("L111_10",  0, 3'd7, 32'h10, 0, 32'hAA001234, 0, 0, 3, 0));
    tbl.push_back(mk("LH_11mis", 0, 3'd1, 32'h11, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk("LW_06mis", 0, 3'd2, 32'h06, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk("L110_12",  0, 3'd6, 32'h12, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk("SW_102",   1, 3'd2, 32'h102, 32'h5, 0, 1, 0, 1, 0));
    tbl.push_back(mk("LH_3FE",   0, 3'd1, 32'h3FE, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("LW_3FC",   0, 3'd2, 32'h3FC, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk("LB_3FD",   0, 3'd0, 32'h3FD, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("LB_wrap",  0, 3'd0, 32'hFFFFFFFE, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("SB_3FC",   1, 3'd0, 32'h3FC, 32'h11, 0, 0, 0, 4, 32'h00000011));
    tbl.push_back(mk("LBU_3FC",  0, 3'd4, 32'h3FC, 0, 32'h11, 0, 0, 3, 0));

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rd, m_mis, m_rng, m_lat, m_ww);
      run_req(tbl[i].name, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata,
              tbl[i].exp_mis, tbl[i].exp_rng, tbl[i].exp_lat, tbl[i].exp_wword);
    end

    // Back-pressure: req_valid stays high with a different store while a load is in flight.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'd0;
    @(posedge clk);
    #1 req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    nwr = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (mem_write) nwr++;
      chk($sformatf("bp ready c%0d", c), 32'(req_ready), 32'd0);
    end
    chk("bp resp_valid", 32'(resp_valid), 32'd1);
    chk("bp rdata", resp_rdata, 32'hAA001234);
    ecl++;
    req_valid = 1'b0;
    @(negedge clk);
    if (mem_write) nwr++;
    chk("bp ready_after", 32'(req_ready), 32'd1);
    chk("bp no_write", 32'(nwr), 32'd0);
    model(0, 3'd2, 32'h20, 0, m_rd, m_mis, m_rng, m_lat, m_ww);
    run_req("bp LW_20", 0, 3'd2, 32'h20, 0, m_rd, m_mis, m_rng, m_lat, m_ww);

    // Reset while the RMW merge is pending: the write must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h14; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst rmw_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst resp", {29'd0, resp_valid, resp_misaligned, resp_range_err}, 32'd0);
    chk("rst ready", 32'(req_ready), 32'd1);
    ecl = 0; ecs = 0; ecf = 0;
`ifdef LSU_ACCESS_CNT_EN
    chk("rst counters", load_cnt | store_cnt | fault_cnt, 32'd0);
`endif
    reset_n = 1'b1;
    model(0, 3'd2, 32'h14, 0, m_rd, m_mis, m_rng, m_lat, m_ww);
    run_req("rst LW_14", 0, 3'd2, 32'h14, 0, m_rd, m_mis, m_rng, m_lat, m_ww);

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 7) addr = 32'($urandom_range(0, 255));
      else if (r < 9) addr = 32'($urandom_range(0, 1100));
      else addr = $urandom;
      wd = $urandom;
      model(we, f3, addr, wd, m_rd, m_mis, m_rng, m_lat, m_ww);
      run_req($sformatf("rnd%0d", i), we, f3, addr, wd, m_rd, m_mis, m_rng, m_lat, m_ww);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
